core_sequencer: RTL and testbench



---
 rtl/core_pkg.sv | 23 ++
 rtl/core_sequencer.sv | 149 ++++++++++++++
 tb/tb_core_sequencer.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/core_pkg.sv
// Shared types and constants for the multi-cycle RV32 core sequencer.
// Holds the sequencer state encoding, writeback source select and address select values.
package core_pkg;

    typedef enum logic [2:0] {
        FETCH     = 3'd0,
        DECODE    = 3'd1,
        EXECUTE   = 3'd2,
        MEM       = 3'd3,
        WRITEBACK = 3'd4,
        TRAP      = 3'd5
    } seq_state_t;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_t;

    localparam logic ADDR_SEL_PC  = 1'b0;
    localparam logic ADDR_SEL_ALU = 1'b1;

endpackage

// File: rtl/core_sequencer.sv
// Multi-cycle sequencer: owns PC and retire counter, steps FETCH..WRITEBACK and
// turns decoder enables into one-cycle strobes for register file, ALU and memory port.
module core_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        dec_mem_read,
    input  logic        dec_mem_write,
    input  logic        dec_reg_write,
    input  logic        dec_jump,
    input  logic        ir_zero,
    input  logic [31:0] jump_target,
    input  logic        mem_ready,
    output logic [31:0] pc,
    output logic        ir_we,
    output logic        mem_req,
    output logic        mem_we,
    output logic        mem_addr_sel,
    output logic        alu_en,
    output logic        rf_we,
    output logic [1:0]  wb_sel,
    output logic        trap,
    output logic [31:0] instret
);

    seq_state_t  state_r;
    seq_state_t  state_next_s;
    logic [31:0] pc_r;
    logic [31:0] target_r;
    logic [31:0] instret_r;
    wb_sel_t     wb_sel_s;

    // Sequencer state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= FETCH;
        end else begin
            state_r <= state_next_s;
        end
    end

    // PC, captured jump target and retire counter; PC/instret move only when leaving WRITEBACK.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r      <= RESET_PC;
            target_r  <= 32'h0000_0000;
            instret_r <= 32'h0000_0000;
        end else begin
            case (state_r)
                EXECUTE: begin
                    if (dec_jump) begin
                        target_r <= jump_target;
                    end
                end
                WRITEBACK: begin
                    pc_r      <= dec_jump ? target_r : (pc_r + 32'd4);
                    instret_r <= instret_r + 32'd1;
                end
                default: begin
                    target_r <= target_r;
                end
            endcase
        end
    end

    // Next-state and strobe decode; while reset is held every strobe is forced low.
    always_comb begin
        state_next_s = state_r;
        ir_we        = 1'b0;
        mem_req      = 1'b0;
        mem_we       = 1'b0;
        mem_addr_sel = ADDR_SEL_PC;
        alu_en       = 1'b0;
        rf_we        = 1'b0;
        wb_sel_s     = WB_ALU;
        trap         = 1'b0;
        if (!rst_n) begin
            state_next_s = FETCH;
        end else begin
            case (state_r)
                FETCH: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = ADDR_SEL_PC;
                    if (mem_ready) begin
                        ir_we        = 1'b1;
                        state_next_s = DECODE;
                    end else begin
                        state_next_s = FETCH;
                    end
                end
                DECODE: begin
                    if (ir_zero) begin
                        state_next_s = WRITEBACK;
                    end else if (dec_mem_read && dec_mem_write) begin
                        state_next_s = TRAP;
                    end else begin
                        state_next_s = EXECUTE;
                    end
                end
                EXECUTE: begin
                    alu_en = 1'b1;
                    if (dec_jump && (jump_target[1:0] != 2'b00)) begin
                        state_next_s = TRAP;
                    end else if (dec_mem_read || dec_mem_write) begin
                        state_next_s = MEM;
                    end else begin
                        state_next_s = WRITEBACK;
                    end
                end
                MEM: begin
                    mem_req      = 1'b1;
                    mem_addr_sel = ADDR_SEL_ALU;
                    mem_we       = dec_mem_write;
                    if (mem_ready) begin
                        state_next_s = WRITEBACK;
                    end else begin
                        state_next_s = MEM;
                    end
                end
                WRITEBACK: begin
                    rf_we = dec_reg_write && !ir_zero;
                    if (dec_jump) begin
                        wb_sel_s = WB_PC4;
                    end else if (dec_mem_read) begin
                        wb_sel_s = WB_MEM;
                    end else begin
                        wb_sel_s = WB_ALU;
                    end
                    state_next_s = FETCH;
                end
                TRAP: begin
                    trap         = 1'b1;
                    state_next_s = TRAP;
                end
                default: begin
                    state_next_s = TRAP;
                end
            endcase
        end
    end

    assign pc      = pc_r;
    assign instret = instret_r;
    assign wb_sel  = wb_sel_s;

endmodule

// File: tb/tb_core_sequencer.sv
// Scoreboard bench for core_sequencer: each instruction queues its expected per-cycle
// strobe pattern, which is popped and compared cycle by cycle, then PC/instret are checked.
module tb_core_sequencer;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        dec_mem_read, dec_mem_write, dec_reg_write, dec_jump, ir_zero;
    logic [31:0] jump_target;
    logic        mem_ready;
    logic [31:0] pc, instret;
    logic        ir_we, mem_req, mem_we, mem_addr_sel, alu_en, rf_we, trap;
    logic [1:0]  wb_sel;

    int checks = 0;
    int errors = 0;
    logic [31:0] exp_pc = 32'h0;
    logic [31:0] exp_instret = 32'h0;

    typedef struct packed {
        logic       rdy;
        logic [8:0] outs;
    } cyc_t;

    cyc_t sb_q[$];

    wire [8:0] act = {mem_req, mem_we, mem_addr_sel, ir_we, alu_en, rf_we, wb_sel, trap};

    core_sequencer #(.RESET_PC(32'h0000_0000)) dut (
        .clk(clk), .rst_n(rst_n),
        .dec_mem_read(dec_mem_read), .dec_mem_write(dec_mem_write),
        .dec_reg_write(dec_reg_write), .dec_jump(dec_jump), .ir_zero(ir_zero),
        .jump_target(jump_target), .mem_ready(mem_ready),
        .pc(pc), .ir_we(ir_we), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr_sel(mem_addr_sel), .alu_en(alu_en), .rf_we(rf_we),
        .wb_sel(wb_sel), .trap(trap), .instret(instret)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] pk(input logic req, input logic we, input logic sel,
                                      input logic irwe, input logic alu, input logic rfwe,
                                      input logic [1:0] wb, input logic tr);
        return {req, we, sel, irwe, alu, rfwe, wb, tr};
    endfunction

    task automatic push(input logic rdy, input logic [8:0] o);
        cyc_t e;
        e.rdy  = rdy;
        e.outs = o;
        sb_q.push_back(e);
    endtask

    task automatic run(input string name, input logic ld, input logic st, input logic rw,
                       input logic jmp, input logic nop, input logic [31:0] tgt,
                       input int fw, input int mw, input int abort_at);
        cyc_t e;
        logic bad;
        int idx;
        logic [31:0] pre_instret;
        dec_mem_read  = ld;
        dec_mem_write = st;
        dec_reg_write = rw;
        dec_jump      = jmp;
        ir_zero       = nop;
        jump_target   = tgt;
        sb_q.delete();
        bad = 1'b0;
        for (int i = 0; i < fw; i++) push(1'b0, pk(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
        push(1'b1, pk(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'd0, 1'b0));
        push(1'b1, 9'd0);
        if (nop) begin
            bad = 1'b0;
        end else if (ld && st) begin
            bad = 1'b1;
        end else begin
            push(1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 2'd0, 1'b0));
            if (jmp && (tgt[1:0] != 2'b00)) begin
                bad = 1'b1;
            end else if (ld || st) begin
                for (int i = 0; i < mw; i++) push(1'b0, pk(1'b1, st, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
                push(1'b1, pk(1'b1, st, 1'b1, 1'b0, 1'b0, 1'b0, 2'd0, 1'b0));
            end
        end
        if (bad) begin
            for (int i = 0; i < 4; i++) push(1'b1, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 2'd0, 1'b1));
        end else begin
            push(1'b0, pk(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, rw && !nop,
                          jmp ? 2'd2 : (ld ? 2'd1 : 2'd0), 1'b0));
        end
        idx = 0;
        while (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            @(negedge clk);
            mem_ready = e.rdy;
            #1;
            checks++;
            if (act !== e.outs) begin
                errors++;
                $display("FAIL %s cycle %0d: strobes got %b want %b", name, idx, act, e.outs);
            end
            if (idx == abort_at) begin
                pre_instret = exp_instret;
                rst_n = 1'b0;
                #1;
                checks++;
                if (mem_req !== 1'b0) begin
                    errors++;
                    $display("FAIL %s abort_mem_req: got %b want 0", name, mem_req);
                end
                checks++;
                if (pc !== 32'h0 || instret !== pre_instret) begin
                    errors++;
                    $display("FAIL %s abort_state: pc %h instret %h want pc 0 instret %h",
                             name, pc, instret, pre_instret);
                end
                sb_q.delete();
                exp_pc = 32'h0;
                exp_instret = 32'h0;
                @(negedge clk);
                rst_n = 1'b1;
                mem_ready = 1'b0;
                return;
            end
            idx++;
        end
        if (!bad) begin
            exp_pc = jmp ? tgt : (exp_pc + 32'd4);
            exp_instret = exp_instret + 32'd1;
        end
        @(posedge clk);
        #1;
        checks++;
        if (pc !== exp_pc || instret !== exp_instret) begin
            errors++;
            $display("FAIL %s retire: pc %h instret %h want pc %h instret %h",
                     name, pc, instret, exp_pc, exp_instret);
        end
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        {dec_mem_read, dec_mem_write, dec_reg_write, dec_jump, ir_zero} = 5'b0;
        jump_target = 32'h0;
        #12;
        checks++;
        if (act !== 9'd0 || pc !== 32'h0 || instret !== 32'h0) begin
            errors++;
            $display("FAIL reset: strobes %b pc %h instret %h want 0 0 0", act, pc, instret);
        end
        exp_pc = 32'h0;
        exp_instret = 32'h0;
        @(negedge clk);
        rst_n = 1'b1;
        mem_ready = 1'b0;
    endtask

    task automatic test_reset_abort;
        run("lw_abort", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 3, 4);
    endtask

    task automatic test_add;
        run("add", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0, -1);
    endtask

    task automatic test_lw_waits;
        run("lw_wait", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 2, 3, -1);
    endtask

    task automatic test_store;
        run("sw", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, 1, 1, -1);
    endtask

    task automatic test_jal;
        run("jal", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0100, 0, 0, -1);
    endtask

    task automatic test_nop;
        run("nop", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 0, 0, -1);
    endtask

    task automatic test_pc_wrap;
        run("jal_top", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 0, 0, -1);
        run("nop_wrap", 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 32'h0, 0, 0, -1);
    endtask

    task automatic test_back_to_back;
        int k;
        for (int i = 0; i < 8; i++) begin
            k = $urandom_range(0, 2);
            case (k)
                0: run("b2b_add", 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, $urandom_range(0, 2), 0, -1);
                1: run("b2b_lw", 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, $urandom_range(0, 2), $urandom_range(0, 2), -1);
                default: run("b2b_sw", 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0, $urandom_range(0, 2), $urandom_range(0, 2), -1);
            endcase
        end
    endtask

    task automatic test_misaligned_jump;
        run("jal_misaligned", 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0000_0102, 0, 0, -1);
    endtask

    task automatic test_illegal;
        run("ld_st_illegal", 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 0, 0, -1);
    endtask

    initial begin
        test_reset;
        test_reset_abort;
        test_add;
        test_lw_waits;
        test_store;
        test_jal;
        test_nop;
        test_pc_wrap;
        test_back_to_back;
        test_misaligned_jump;
        test_reset;
        test_illegal;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
